smg_arb: RTL and testbench
==========================

# smg_arb

Round-robin arbiter that shares the single seven-segment serial interface (`smg_interface`, 74HC595 shift chain) between several requesters. Each requester posts a digit update (digit index plus 4-bit value). The arbiter grants one at a time, drives `smg_no`, `smg_data` and the one-cycle `smg_update` strobe into `smg_interface`, then enforces a minimum spacing so that each shift/latch sequence completes before the next update. It sits between display clients (counters, status sources) and `smg_interface` in the display top level.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `GAP`, default 40: minimum clock cycles between consecutive `smg_update` pulses, must be ≥3. Sized to cover one full `smg_interface` shift-and-latch.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-high reset. 1 means reset; the port name is kept for top-level compatibility.
- `req` in N_REQ: per-requester update request, level, held until acked.
- `req_no` in 2·N_REQ: digit index, requester i at bits [2i+1:2i].
- `req_data` in 4·N_REQ: digit value, requester i at bits [4i+3:4i].
- `ack` out N_REQ: one-hot, one-cycle grant/consume pulse.
- `smg_no` out 2: digit index to `smg_interface`.
- `smg_data` out 4: digit value to `smg_interface`.
- `smg_update` out 1: one-cycle load strobe to `smg_interface`.
- `busy` out 1: high in ISSUE and HOLD.

## Operation
- **Reset values:** state IDLE, `ack`=0, `smg_no`=0, `smg_data`=0, `smg_update`=0, `busy`=0, round-robin pointer=0, gap counter=0.
- **IDLE**
  - If `req`≠0, pick the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Register that requester's `req_no`/`req_data` into `smg_no`/`smg_data`, record the grant index, and go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (exactly one cycle)
  - `smg_update`=1 and `ack[grant]`=1 in the same cycle.
  - Pointer becomes (grant+1) mod N_REQ.
  - Gap counter loads GAP−3; go to HOLD.
- **HOLD**
  - Gap counter decrements each cycle; at 0, go to IDLE.
  - New requests are ignored until IDLE.
- `smg_no`/`smg_data` hold their value from the last grant until the next grant. They never change during ISSUE or HOLD.
- **Requester contract:** hold `req`, `req_no` and `req_data` stable until `ack`. Dropping `req` before `ack` withdraws the request.
  - The sample is taken at the IDLE decision edge. A withdrawal after that edge still completes that grant, including its `ack`.
- Deassert `req` in the cycle after `ack`. A `req` still high in the next IDLE is treated as a new request.
- **Reset mid-operation:** any state goes to IDLE next edge with all reset values. An in-flight grant is abandoned; no `ack` and no `smg_update` are issued for it.
- **Fairness:** with all requesters permanently active, grants rotate 0,1,…,N_REQ−1,0,…

## Timing
- **Latency:** `req` high and sampled in IDLE at edge t gives `smg_update`/`ack` high in cycle t+1.
- **Back-to-back spacing:** IDLE (1) + ISSUE (1) + HOLD (GAP−2) gives `smg_update` pulses exactly GAP cycles apart under continuous requests. This is also the minimum spacing.
- `busy` is high for GAP−1 cycles per grant.
- The gap counter is ⌈log2(GAP)⌉ bits, unsigned, with no wrap.
- **Simultaneous requests in IDLE:** the pointer decides. A request arriving during HOLD waits; worst-case wait is N_REQ·GAP cycles.

## Structure
- Package `smg_pkg`:
  - state enum {IDLE, ISSUE, HOLD};
  - `SMG_NO_W`=2 and `SMG_DATA_W`=4;
  - default `GAP` constant.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and pointer; outputs are `found` and the grant index. The FSM, registers and gap counter stay in `smg_arb`.

## Test plan
- **Reset:** hold `rst_n`=1 for 3 cycles, then release. All outputs are 0 and no `smg_update` appears with `req`=0.
- **Single request:** `req`=4'b0100, `req_no`[5:4]=2, `req_data`[11:8]=7.
  - Next cycle: `smg_update`=1, `ack`=4'b0100, `smg_no`=2, `smg_data`=7.
  - `busy` stays high for 39 cycles.
- **All four requesting continuously** (GAP=40): grants occur in order 0,1,2,3,0 with `smg_update` exactly 40 cycles apart. Each `smg_no` equals the granting requester's index.
- **Request during HOLD:** req1 arrives 5 cycles after the grant to req0. It is issued exactly 40 cycles after req0's `smg_update`, and `smg_data` is unchanged during HOLD.
- **Reset mid-HOLD:** assert reset 10 cycles into HOLD. The block returns to IDLE next edge. After release with req0 pending, the pointer is 0 and the grant goes to req0 one cycle after the IDLE sample.
- **Withdrawal:** req2 rises and falls while in HOLD. No `ack[2]` is issued and no `smg_update` occurs for it.

Source files
------------

// File: rtl/smg_pkg.sv
// Shared types and constants for the seven-segment update arbiter.
package smg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int SMG_NO_W    = 2;
  localparam int SMG_DATA_W  = 4;
  localparam int GAP_DEFAULT = 40;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             found,
  output logic [IW-1:0]    idx
);

  logic [IW:0] pos;
  logic        hit;

  // Scan from the pointer outward; the first hit wins and later hits are masked.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pos   = {1'b0, ptr} + (IW+1)'(k);
      pos   = (pos >= (IW+1)'(N_REQ)) ? pos - (IW+1)'(N_REQ) : pos;
      hit   = ~found & req[pos[IW-1:0]];
      idx   = hit ? pos[IW-1:0] : idx;
      found = found | hit;
    end
  end

endmodule

// File: rtl/smg_arb.sv
// Round-robin arbiter sharing one smg_interface among N_REQ digit-update requesters,
// spacing smg_update pulses GAP cycles apart so each shift/latch completes.
module smg_arb
  import smg_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GAP   = GAP_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [SMG_NO_W*N_REQ-1:0]    req_no,
  input  logic [SMG_DATA_W*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]             ack,
  output logic [SMG_NO_W-1:0]          smg_no,
  output logic [SMG_DATA_W-1:0]        smg_data,
  output logic                         smg_update,
  output logic                         busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP);
  // HOLD lasts GAP-2 cycles (counter GAP-3 down to 0), giving a GAP-cycle period.
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 3);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  state_e                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           gap_q, gap_d;
  logic [SMG_NO_W-1:0]     no_q, no_d;
  logic [SMG_DATA_W-1:0]   data_q, data_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic                    upd_q, upd_d;
  logic                    busy_q, busy_d;

  logic                    pick_found;
  logic [IW-1:0]           pick_idx;
  logic [SMG_NO_W-1:0]     sel_no;
  logic [SMG_DATA_W-1:0]   sel_data;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the picked requester's digit index and value.
  always_comb begin
    sel_no   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_no   = (pick_idx == IW'(i)) ? req_no[i*SMG_NO_W +: SMG_NO_W] : sel_no;
      sel_data = (pick_idx == IW'(i)) ? req_data[i*SMG_DATA_W +: SMG_DATA_W] : sel_data;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    no_d    = no_q;
    data_d  = data_q;
    ack_d   = '0;
    upd_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = ISSUE;
          grant_d = pick_idx;
          no_d    = sel_no;
          data_d  = sel_data;
          ack_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          upd_d   = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        ptr_d   = (grant_q == LAST_IDX) ? {IW{1'b0}} : grant_q + IW'(1);
        gap_d   = GAP_LOAD;
        state_d = HOLD;
        busy_d  = 1'b1;
      end
      HOLD: begin
        if (gap_q == {GW{1'b0}}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d   = gap_q - GW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; rst_n is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      gap_q   <= '0;
      no_q    <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      no_q    <= no_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      upd_q   <= upd_d;
      busy_q  <= busy_d;
    end
  end

  assign ack        = ack_q;
  assign smg_no     = no_q;
  assign smg_data   = data_q;
  assign smg_update = upd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_smg_arb.sv
// Directed self-checking bench for smg_arb (N_REQ=4, GAP=40).
module tb_smg_arb;

  localparam int GAP = 40;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  req_no;
  logic [15:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  smg_no;
  logic [3:0]  smg_data;
  logic        smg_update;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  no;
    logic [15:0] data;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_no;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs [7];

  smg_arb #(.N_REQ(4), .GAP(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_no     (req_no),
    .req_data   (req_data),
    .ack        (ack),
    .smg_no     (smg_no),
    .smg_data   (smg_data),
    .smg_update (smg_update),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Apply one vector from IDLE, check the issue cycle, the hold window and the return to IDLE.
  task automatic run_vec(input int k);
    int busy_n;
    int extra_upd;
    int unstable;
    req      = vecs[k].req;
    req_no   = vecs[k].no;
    req_data = vecs[k].data;
    step();
    chk($sformatf("v%0d_update", k), 32'(smg_update), 32'd1);
    chk($sformatf("v%0d_ack", k), 32'(ack), 32'(vecs[k].exp_ack));
    chk($sformatf("v%0d_no", k), 32'(smg_no), 32'(vecs[k].exp_no));
    chk($sformatf("v%0d_data", k), 32'(smg_data), 32'(vecs[k].exp_data));
    req = 4'b0000;
    busy_n    = busy ? 1 : 0;
    extra_upd = 0;
    unstable  = 0;
    for (int i = 0; i < GAP - 2; i++) begin
      step();
      if (busy) busy_n++;
      if (smg_update || ack != 4'b0000) extra_upd++;
      if (smg_no != vecs[k].exp_no || smg_data != vecs[k].exp_data) unstable++;
    end
    step();
    chk($sformatf("v%0d_busy_len", k), 32'(busy_n), 32'(GAP - 1));
    chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'd0);
    chk($sformatf("v%0d_hold_quiet", k), 32'(extra_upd), 32'd0);
    chk($sformatf("v%0d_hold_stable", k), 32'(unstable), 32'd0);
  endtask

  initial begin
    int n;
    int last;
    int t0;
    int unstable;
    int seen;
    int cnt_upd;
    int cnt_ack2;

    vecs[0] = '{4'b0100, 8'b01_10_11_00, 16'h3759, 4'b0100, 2'd2, 4'h7};
    vecs[1] = '{4'b0011, 8'b00_01_10_11, 16'hABCD, 4'b0001, 2'd3, 4'hD};
    vecs[2] = '{4'b1001, 8'b10_00_00_01, 16'h1234, 4'b1000, 2'd2, 4'h1};
    vecs[3] = '{4'b1111, 8'b11_10_01_00, 16'hFEDC, 4'b0001, 2'd0, 4'hC};
    vecs[4] = '{4'b0001, 8'b00_00_00_10, 16'h000E, 4'b0001, 2'd2, 4'hE};
    vecs[5] = '{4'b0110, 8'b00_11_01_00, 16'h0560, 4'b0010, 2'd1, 4'h6};
    vecs[6] = '{4'b0010, 8'b00_00_11_00, 16'h00F0, 4'b0010, 2'd3, 4'hF};

    // Reset and quiet idle
    rst_n = 1'b1; req = 4'b0000; req_no = 8'h00; req_data = 16'h0000;
    repeat (3) step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_update", 32'(smg_update), 32'd0);
    chk("rst_no_data", 32'({smg_no, smg_data}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b0;
    cnt_upd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (smg_update || busy) cnt_upd++;
    end
    chk("idle_quiet", 32'(cnt_upd), 32'd0);

    // Table of single grants; the pointer carries over from one vector to the next
    for (int k = 0; k < 7; k++) run_vec(k);

    // Continuous requests from a fresh reset: 0,1,2,3,0 exactly GAP apart
    rst_n = 1'b1; step(); step();
    rst_n = 1'b0;
    req = 4'b1111; req_no = 8'b11_10_01_00; req_data = 16'h4321;
    n = 0; last = 0;
    for (int c = 0; c < 300 && n < 5; c++) begin
      step();
      if (smg_update) begin
        chk($sformatf("rr%0d_ack", n), 32'(ack), 32'(4'b0001 << (n % 4)));
        chk($sformatf("rr%0d_no", n), 32'(smg_no), 32'(n % 4));
        chk($sformatf("rr%0d_data", n), 32'(smg_data), 32'((n % 4) + 1));
        if (n > 0) chk($sformatf("rr%0d_spacing", n), 32'(cyc - last), 32'(GAP));
        last = cyc;
        n++;
      end
    end
    chk("rr_grant_count", 32'(n), 32'd5);
    req = 4'b0000;
    for (int c = 0; c < 100 && busy; c++) step();
    chk("rr_drain", 32'(busy), 32'd0);

    // Request arriving during HOLD waits for the next IDLE
    req = 4'b0001; req_no = 8'b00_00_00_10; req_data = 16'h0005;
    step();
    t0 = cyc;
    chk("hold_first_ack", 32'(ack), 32'd1);
    req = 4'b0000;
    repeat (5) step();
    req = 4'b0010; req_no = 8'b00_00_11_10; req_data = 16'h00A5;
    unstable = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (smg_update) begin
        seen = 1;
        break;
      end
      if (smg_no != 2'd2 || smg_data != 4'h5) unstable++;
    end
    chk("hold_req_seen", 32'(seen), 32'd1);
    chk("hold_req_spacing", 32'(cyc - t0), 32'(GAP));
    chk("hold_req_ack", 32'(ack), 32'b0010);
    chk("hold_req_no_data", 32'({smg_no, smg_data}), 32'({2'd3, 4'hA}));
    chk("hold_data_stable", 32'(unstable), 32'd0);
    req = 4'b0000;

    // Reset 10 cycles into HOLD; pointer (2 before reset) must restart at 0
    repeat (10) step();
    rst_n = 1'b1;
    req = 4'b0101; req_no = 8'b00_01_00_11; req_data = 16'h0906;
    step();
    chk("mid_rst_outputs", 32'({ack, smg_update, busy, smg_no, smg_data}), 32'd0);
    rst_n = 1'b0;
    step();
    chk("post_rst_update", 32'(smg_update), 32'd1);
    chk("post_rst_ack", 32'(ack), 32'b0001);
    chk("post_rst_no_data", 32'({smg_no, smg_data}), 32'({2'd3, 4'h6}));
    req = 4'b0000;

    // req2 rises and falls within HOLD: withdrawn, never granted
    repeat (10) step();
    req = 4'b0100;
    repeat (5) step();
    req = 4'b0000;
    cnt_upd = 0; cnt_ack2 = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (smg_update) cnt_upd++;
      if (ack[2]) cnt_ack2++;
    end
    chk("withdraw_update", 32'(cnt_upd), 32'd0);
    chk("withdraw_ack2", 32'(cnt_ack2), 32'd0);
    chk("withdraw_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
